// File: rtl/alu_pkg.sv
// Shared ALU definitions: op encoding, datapath widths and the
// multiplier controller state encoding.
package alu_pkg;

    localparam int W  = 16;  // operand width, matches alu
    localparam int CW = 5;   // iteration counter width, covers 0..16

    typedef enum logic [1:0] {
        ALU_ADD = 2'b00,
        ALU_SUB = 2'b01,
        ALU_AND = 2'b10,
        ALU_OR  = 2'b11
    } alu_op_t;

    // Code 2'd3 is unused and recovers to IDLE.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } mul_state_t;

endpackage

// File: rtl/alu_mul_seq_if.sv
// Request/result bundle between a requester and the sequential multiplier.
//
// Handshake: start is sampled on a rising clk edge only while busy=0
// (IDLE or DONE); that edge captures a and b. While busy=1 start, a and b
// are ignored. done is a one-cycle pulse marking the cycle from which
// product holds the new result; product stays stable until the next done
// or reset. busy and done are never high together.
interface alu_mul_seq_if;
    import alu_pkg::*;

    logic             start;
    logic [W-1:0]     a;
    logic [W-1:0]     b;
    logic             busy;
    logic             done;
    logic [2*W-1:0]   product;

    modport master (
        output start, a, b,
        input  busy, done, product
    );

    modport slave (
        input  start, a, b,
        output busy, done, product
    );

endinterface

// File: rtl/alu.sv
// 16-bit ALU: ADD, SUB, AND, OR with carry out. SUB is an add of the
// inverted operand with an internal carry-in of 1; ADD uses carry-in 0.
module alu
    import alu_pkg::*;
(
    input  logic [W-1:0] i0,
    input  logic [W-1:0] i1,
    input  alu_op_t      op,
    output logic [W-1:0] sum,
    output logic         cout
);

    logic [W:0] ext;
    logic       cin;

    // Combinational result with one extra bit to carry out of the adder.
    always_comb begin
        ext = '0;
        cin = (op == ALU_SUB);
        case (op)
            ALU_ADD: ext = {1'b0, i0} + {1'b0, i1} + {{W{1'b0}}, cin};
            ALU_SUB: ext = {1'b0, i0} + {1'b0, ~i1} + {{W{1'b0}}, cin};
            ALU_AND: ext = {1'b0, i0 & i1};
            ALU_OR:  ext = {1'b0, i0 | i1};
            default: ext = '0;
        endcase
    end

    assign sum  = ext[W-1:0];
    assign cout = ext[W];

endmodule

// File: rtl/alu_mul_seq.sv
// Sequential unsigned 16x16 shift-and-add multiplier that borrows the
// existing alu as its adder. acc holds the running upper half, q the
// multiplier shifting out into the lower half; the alu carry becomes the
// new acc msb so the full 32-bit product is kept.
module alu_mul_seq
    import alu_pkg::*;
(
    input  logic         clk,
    input  logic         reset,
    alu_mul_seq_if.slave bus,
    output mul_state_t   dbg_state
);

    mul_state_t       state;
    logic [W-1:0]     acc;
    logic [W-1:0]     q;
    logic [W-1:0]     m;
    logic [CW-1:0]    cnt;
    logic [2*W-1:0]   product_q;

    logic [W-1:0]     addend;
    logic [W-1:0]     alu_sum;
    logic             alu_cout;

    // Add the multiplicand only when the current multiplier bit is set.
    assign addend = q[0] ? m : '0;

    alu u_alu (
        .i0   (acc),
        .i1   (addend),
        .op   (ALU_ADD),
        .sum  (alu_sum),
        .cout (alu_cout)
    );

    // Controller FSM, iteration counter and shift registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= IDLE;
            acc       <= '0;
            q         <= '0;
            m         <= '0;
            cnt       <= '0;
            product_q <= '0;
        end else begin
            case (state)
                // DONE accepts a new start exactly like IDLE, so multiplies
                // can run back to back with no idle gap.
                IDLE, DONE: begin
                    if (bus.start) begin
                        m     <= bus.a;
                        q     <= bus.b;
                        acc   <= '0;
                        cnt   <= '0;
                        state <= RUN;
                    end else begin
                        state <= IDLE;
                    end
                end
                RUN: begin
                    {acc, q} <= {alu_cout, alu_sum, q[W-1:1]};
                    cnt      <= cnt + CW'(1);
                    if (cnt == CW'(W - 1)) begin
                        product_q <= {alu_cout, alu_sum, q[W-1:1]};
                        state     <= DONE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.busy    = (state == RUN);
    assign bus.done    = (state == DONE);
    assign bus.product = product_q;
    assign dbg_state   = state;

endmodule
